// File: rtl/apb_pkg.sv
// Shared APB definitions for the byte-wide register memory completer.
// Bus widths, FSM state encoding and PSLVERR reason codes.
package apb_pkg;

  localparam int APB_ADDR_W = 9;
  localparam int APB_DATA_W = 8;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  // Reason codes are not driven on the bus; they let a bench classify errors.
  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_RANGE     = 2'd1;
  localparam logic [1:0] ERR_UNWRITTEN = 2'd2;

endpackage

// File: rtl/apb_slave_mem_if.sv
// APB bus bundle between the master/decoder side and the memory completer.
// Clock and reset stay outside the bundle as plain ports.
interface apb_slave_mem_if;
  import apb_pkg::*;

  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [APB_ADDR_W-1:0] PADDR;
  logic [APB_DATA_W-1:0] PWDATA;
  logic [APB_DATA_W-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_slave_ram.sv
// DEPTH x 8 storage with a per-entry written flag; synchronous write, async read.
// The memory array itself is not reset, only the written flags are.
module apb_slave_ram #(
  parameter int DEPTH = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] addr,
  input  logic       we,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       valid
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [8:0] DEPTH_LIM = 9'(DEPTH);

  logic [7:0]       mem [DEPTH];
  logic [DEPTH-1:0] valid_map;
  logic [IDX_W-1:0] idx;
  logic             in_range;
  logic [7:0]       unused_addr;

  assign idx         = addr[IDX_W-1:0];
  assign in_range    = ({1'b0, addr} < DEPTH_LIM);
  assign unused_addr = addr;

  always_ff @(posedge clk) begin
    if (we && in_range) begin
      mem[idx] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_map <= '0;
    end else if (we && in_range) begin
      valid_map[idx] <= 1'b1;
    end
  end

  // Out-of-range lookups read as unwritten zeros rather than aliasing.
  assign rdata = in_range ? mem[idx] : 8'h00;
  assign valid = in_range ? valid_map[idx] : 1'b0;

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer over apb_slave_ram: latches the setup phase, stalls WAIT_CYCLES,
// and flags out-of-range or never-written reads with PSLVERR.
//
//   state  | meaning
//   IDLE   | waiting for a setup cycle (PSEL=1, PENABLE=0)
//   ACCESS | request latched; counting wait cycles, completes when count is 0
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 1
) (
  input  logic            PCLK,
  input  logic            PRESETn,
  apb_slave_mem_if.slave  bus
);

  localparam logic [0:0] ST_IDLE   = IDLE;
  localparam logic [0:0] ST_ACCESS = ACCESS;
  localparam logic [3:0] CNT_INIT  = 4'(WAIT_CYCLES);
  localparam logic [8:0] DEPTH_LIM = 9'(DEPTH);

  logic [0:0] state;
  logic [3:0] cnt;
  logic [7:0] req_addr;
  logic       req_write;
  logic [7:0] req_wdata;

  logic [7:0] ram_rdata;
  logic       ram_valid;
  logic       in_range;
  logic       err;
  logic       ready;
  logic       commit;
  logic       unused_addr_msb;

  // Bit 8 is the decoder's select; it has already done its job upstream.
  assign unused_addr_msb = bus.PADDR[8];

  assign in_range = ({1'b0, req_addr} < DEPTH_LIM);
  assign err      = !in_range || (!req_write && !ram_valid);
  assign ready    = (state == ST_ACCESS) && (cnt == 4'd0);
  assign commit   = ready && bus.PSEL && bus.PENABLE && req_write && !err;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      req_addr  <= 8'h00;
      req_write <= 1'b0;
      req_wdata <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.PSEL && !bus.PENABLE) begin
            req_addr  <= bus.PADDR[7:0];
            req_write <= bus.PWRITE;
            req_wdata <= bus.PWDATA;
            cnt       <= CNT_INIT;
            state     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (!bus.PSEL || !bus.PENABLE) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

  apb_slave_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .addr  (req_addr),
    .we    (commit),
    .wdata (req_wdata),
    .rdata (ram_rdata),
    .valid (ram_valid)
  );

  // Responses depend only on state, counter and the latched request.
  assign bus.PREADY  = ready;
  assign bus.PSLVERR = ready && err;
  assign bus.PRDATA  = (ready && !req_write && !err) ? ram_rdata : 8'h00;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem (DEPTH=64, WAIT_CYCLES=1).
// Inputs change on the falling edge; outputs are sampled 1ns after it.
module tb_apb_slave_mem;
  import apb_pkg::*;

  logic PCLK;
  logic PRESETn;
  int   n_checks;
  int   n_errors;

  apb_slave_mem_if bus ();

  apb_slave_mem #(
    .DEPTH       (64),
    .WAIT_CYCLES (1)
  ) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    @(negedge PCLK);
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
  endtask

  task automatic xfer(input logic wr, input logic [8:0] addr, input logic [7:0] wdata,
                      output logic [7:0] rdata, output logic err, output int cycles);
    logic done;
    @(negedge PCLK);
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = wr;
    bus.PADDR   = addr;
    bus.PWDATA  = wdata;
    cycles = 1;
    rdata  = 8'h00;
    err    = 1'b0;
    done   = 1'b0;
    @(negedge PCLK);
    bus.PENABLE = 1'b1;
    for (int n = 0; n < 40 && !done; n++) begin
      #1;
      cycles++;
      if (bus.PREADY) begin
        rdata = bus.PRDATA;
        err   = bus.PSLVERR;
        done  = 1'b1;
      end else begin
        check("stall_pslverr", 32'(bus.PSLVERR), 32'd0);
        check("stall_prdata", 32'(bus.PRDATA), 32'd0);
        @(negedge PCLK);
      end
    end
    if (!done) check("pready_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_write(input logic [8:0] addr, input logic [7:0] data, input logic [1:0] reason);
    logic [7:0] rd;
    logic       e;
    int         cyc;
    xfer(1'b1, addr, data, rd, e, cyc);
    check("wr_pslverr", 32'(e), 32'(reason != ERR_NONE));
    check("wr_cycles", 32'(cyc), 32'd3);
  endtask

  task automatic do_read(input logic [8:0] addr, input logic [7:0] exp, input logic [1:0] reason);
    logic [7:0] rd;
    logic       e;
    int         cyc;
    xfer(1'b0, addr, 8'h00, rd, e, cyc);
    check("rd_pslverr", 32'(e), 32'(reason != ERR_NONE));
    check("rd_prdata", 32'(rd), 32'(exp));
    check("rd_cycles", 32'(cyc), 32'd3);
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    PRESETn     = 1'b0;
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b0;
    bus.PADDR   = 9'h000;
    bus.PWDATA  = 8'h00;

    #3;
    check("rst_pready", 32'(bus.PREADY), 32'd0);
    check("rst_pslverr", 32'(bus.PSLVERR), 32'd0);
    check("rst_prdata", 32'(bus.PRDATA), 32'd0);
    @(negedge PCLK);
    @(negedge PCLK);
    PRESETn = 1'b1;

    // Nothing written yet.
    do_read(9'd5, 8'h00, ERR_UNWRITTEN);
    bus_idle();

    for (int i = 0; i < 8; i++) do_write(9'(i), 8'(2 * i), ERR_NONE);
    for (int i = 0; i < 8; i++) do_read(9'(i), 8'(2 * i), ERR_NONE);
    bus_idle();

    do_write(9'd100, 8'h33, ERR_RANGE);
    do_read(9'd100, 8'h00, ERR_RANGE);
    do_read(9'd45, 8'h00, ERR_UNWRITTEN);
    bus_idle();

    // Abort during the wait cycle must leave the old data.
    do_write(9'd3, 8'h55, ERR_NONE);
    bus_idle();
    @(negedge PCLK);
    bus.PSEL   = 1'b1;
    bus.PWRITE = 1'b1;
    bus.PADDR  = 9'd3;
    bus.PWDATA = 8'hAA;
    @(negedge PCLK);
    bus.PSEL = 1'b0;
    #1;
    check("abort_pready_wait", 32'(bus.PREADY), 32'd0);
    @(negedge PCLK);
    #1;
    check("abort_pready_after", 32'(bus.PREADY), 32'd0);
    do_read(9'd3, 8'h55, ERR_NONE);

    // Address bit 8 ignored; read directly follows write completion.
    do_write(9'h101, 8'h7E, ERR_NONE);
    do_read(9'h001, 8'h7E, ERR_NONE);
    bus_idle();

    // Reset in the middle of a second write clears the valid flag.
    do_write(9'd2, 8'h11, ERR_NONE);
    do_read(9'd2, 8'h11, ERR_NONE);
    @(negedge PCLK);
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b1;
    bus.PADDR   = 9'd2;
    bus.PWDATA  = 8'h22;
    @(negedge PCLK);
    bus.PENABLE = 1'b1;
    #2;
    PRESETn = 1'b0;
    #1;
    check("midrst_pready", 32'(bus.PREADY), 32'd0);
    check("midrst_pslverr", 32'(bus.PSLVERR), 32'd0);
    check("midrst_prdata", 32'(bus.PRDATA), 32'd0);
    bus_idle();
    @(negedge PCLK);
    PRESETn = 1'b1;
    do_read(9'd2, 8'h00, ERR_UNWRITTEN);
    bus_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/apb_slave_mem.md
# apb_slave_mem

APB completer with a byte-wide register memory, programmable wait states and error signalling. It sits behind the APB master and address decoder on the peripheral bus and answers the master's read and write transfers. It stalls each transfer for a fixed number of access cycles. It raises PSLVERR on out-of-range addresses and on reads of locations never written since reset.

## Interface
Parameters:
- DEPTH, 64 — number of 8-bit entries; legal addresses 0..DEPTH-1 (DEPTH ≤ 256).
- WAIT_CYCLES, 1 — access-phase cycles with PREADY low before completion (0..15).

Ports:
- PCLK  in  1  single clock, all state on rising edge.
- PRESETn  in  1  reset, asynchronous assert, active-low.
- PSEL  in  1  completer select from decoder.
- PENABLE  in  1  access-phase indicator.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  9  address; bit 8 is the decoder's slave select and is ignored here, bits 7:0 index memory.
- PWDATA  in  8  write data.
- PRDATA  out  8  read data.
- PREADY  out  1  transfer completes on the edge where PREADY=1.
- PSLVERR  out  1  error response, valid only when PREADY=1.

## Operation
- FSM states: IDLE and ACCESS.
- IDLE:
  - On PSEL=1 and PENABLE=0 (setup cycle), latch PADDR[7:0], PWRITE and PWDATA.
  - Load wait counter with WAIT_CYCLES and go to ACCESS.
  - PENABLE=1 without a preceding setup is ignored.
- ACCESS:
  - While counter > 0 and PSEL=1: PREADY=0, counter decrements each edge.
  - When counter = 0: PREADY=1, and the transfer completes at that edge; return to IDLE.
- Abort: PSEL=0 or PENABLE=0 while in ACCESS returns the FSM to IDLE. No memory or valid-bit update occurs; PREADY stays 0.
- Error (err), evaluated on the latched address:
  - address ≥ DEPTH, or
  - read with valid[address]=0.
- Write completion:
  - If no err: mem[addr] ← PWDATA latched, and valid[addr] ← 1.
  - If err: no update.
- Read completion: PRDATA = mem[addr] when no err, else 8'h00.
- Outputs outside the completing cycle: PRDATA=8'h00 and PSLVERR=0.
- PREADY, PSLVERR and PRDATA are combinational from FSM state, counter and the latched request only, never from PSEL/PADDR directly.
- Valid bitmap (DEPTH bits) clears on reset. Memory array is not reset.

## Timing
- Reset values: PREADY=0, PSLVERR=0, PRDATA=8'h00, FSM=IDLE, counter=0, valid all 0.
- Reset is asynchronous mid-transfer: the pending write is discarded and outputs drop immediately.
- Transfer length is 2+WAIT_CYCLES cycles (setup + WAIT_CYCLES stalled access + 1 completing access). WAIT_CYCLES=0 gives zero-wait 2-cycle APB.
- Back-to-back: a setup cycle directly following a completion edge is accepted; no idle cycle is required.
- A write and a read of the same address back-to-back returns the new data, because the write commits at its completion edge, before the read's setup.
- Write commit and valid-bit set occur on the same edge.
- A read of a just-written location in the next transfer is never an error.

## Structure
- Shared package apb_pkg holds:
  - APB_ADDR_W=9 and APB_DATA_W=8
  - state enum {IDLE, ACCESS}
  - PSLVERR reason constants ERR_RANGE and ERR_UNWRITTEN, for bench coverage only
- One sub-module, apb_slave_ram:
  - DEPTH×8 array plus valid bitmap
  - synchronous write port, asynchronous read port
  - valid bitmap cleared by PRESETn
- The FSM, wait counter and response muxing stay in apb_slave_mem.

## Test plan
- Reset then read addr 9'd5 → PREADY high in the 2nd access cycle, PSLVERR=1, PRDATA=8'h00; after reset all outputs are 0.
- Write addr i, data 2i for i=0..7, then read addr 0..7:
  - reads return 0,2,4,..,14 with PSLVERR=0
  - each transfer takes exactly 3 cycles with WAIT_CYCLES=1
- Write 9'd100 (≥DEPTH) → PSLVERR=1; a following read of 9'd100 → PSLVERR=1. Read 9'd45 (never written) → PSLVERR=1, PRDATA=8'h00.
- Write 8'h55 to addr 3, then start a write of 8'hAA to addr 3 and drop PSEL during the wait cycle → the next read of 3 returns 8'h55.
- Write 9'h101 data 8'h7E, then read 9'h001 back-to-back with no idle → PRDATA=8'h7E (bit 8 ignored).
- Write addr 2, assert PRESETn=0 mid-transfer of a second write to addr 2, release, then read 2 → PSLVERR=1 (valid cleared).
